fifo_stream_reader: RTL

- Read-side consumer for the team's synchronous FIFO (wen/ren, full/empty, registered dataout).
- Issues ren to the FIFO, captures dataout on the correct cycle, and presents words downstream on a valid/ready stream.
- Holds captured words in a 2-entry prefetch buffer, so the output sustains one word per cycle under continuous out_ready.
- Sits between the FIFO read port and any downstream consumer.

---
 rtl/fifo_stream_reader_pkg.sv | 18 +
 rtl/fifo_stream_reader_prefetch.sv | 51 +++++
 rtl/fifo_stream_reader.sv | 66 ++++++
 3 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the synchronous FIFO and its stream reader.
// can_issue() is the read-issue budget rule for the 2-entry prefetch buffer.
package fifo_pkg;

  localparam int unsigned DATA_W      = 3;
  localparam int unsigned DEPTH       = 8;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned FIFO_RD_LAT = 1;
  localparam int unsigned BUF_DEPTH   = 2;

  // occ + inflight - out_fire < BUF_DEPTH, rearranged so nothing goes negative
  function automatic logic can_issue(input logic [1:0] occ,
                                     input logic [1:0] inflight,
                                     input logic       out_fire);
    return ({1'b0, occ} + {1'b0, inflight}) < (3'(BUF_DEPTH) + {2'b00, out_fire});
  endfunction

endpackage

// File: rtl/fifo_stream_reader_prefetch.sv
// Two-entry prefetch buffer with push/pop/clear; head word is always visible.
module rd_prefetch_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data,
  output logic              valid
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              head;
  logic              tail;
  logic              do_pop;

  assign do_pop    = pop && (occ != 2'd0);
  assign valid     = (occ != 2'd0);
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem  <= '{default: '0};
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else if (clear) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (do_pop)
        head <= ~head;
      if (push && !do_pop)
        occ <= occ + 2'd1;
      else if (!push && do_pop)
        occ <= occ - 2'd1;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the synchronous FIFO: issues reads, captures the
// registered dataout one cycle later, and streams words out on valid/ready.
module fifo_stream_reader #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W,
  parameter int unsigned CNT_W  = fifo_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_ren,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  word_cnt
);
  import fifo_pkg::*;

  logic [FIFO_RD_LAT-1:0] inflight_q;
  logic [1:0]             inflight_cnt;
  logic [1:0]             occ;
  logic                   out_fire;
  logic                   capture;

  assign out_fire = out_valid && out_ready;
  assign capture  = inflight_q[FIFO_RD_LAT-1] && !flush;

  always_comb begin
    inflight_cnt = '0;
    for (int unsigned i = 0; i < FIFO_RD_LAT; i++)
      inflight_cnt = inflight_cnt + {1'b0, inflight_q[i]};
  end

  // out_ready reaches fifo_ren combinationally so a pop frees a slot the same cycle
  assign fifo_ren = rst && !flush && !fifo_empty && can_issue(occ, inflight_cnt, out_fire);

  always_ff @(posedge clk) begin
    if (!rst)
      inflight_q <= '0;
    else
      inflight_q <= (inflight_q << 1) | FIFO_RD_LAT'(fifo_ren);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      word_cnt <= '0;
    else if (out_fire)
      word_cnt <= word_cnt + 1'b1;
  end

  rd_prefetch_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (capture),
    .push_data (fifo_dout),
    .pop       (out_ready),
    .occ       (occ),
    .head_data (out_data),
    .valid     (out_valid)
  );

endmodule
